// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default sizing for the cache refill arbiter
package cache_pkg;
  localparam int WORDS = 8;
  localparam int OFF_W = $clog2(WORDS);
  localparam int MEM_LAT = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/cache_fill_arbiter_counter.sv
// fill_word_counter: saturating word counter with synchronous clear and enable
module fill_word_counter #(
  parameter int W = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: grants the shared memory read port to I/D cache refills
// and steers returning words into the owning cache, D side first.
module cache_fill_arbiter import cache_pkg::*; #(
  parameter int WORDS = cache_pkg::WORDS,
  parameter int MEM_LAT = cache_pkg::MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_miss_i,
  input  logic [15:0]              i_miss_addr_i,
  input  logic                     d_miss_i,
  input  logic [15:0]              d_miss_addr_i,
  output logic                     mem_en_o,
  output logic [15:0]              mem_addr_o,
  input  logic                     mem_data_valid_i,
  input  logic [15:0]              mem_data_in_i,
  output logic                     fill_we_i_o,
  output logic                     fill_we_d_o,
  output logic [$clog2(WORDS)-1:0] fill_word_o,
  output logic [15:0]              fill_data_o,
  output logic                     tag_we_i_o,
  output logic                     tag_we_d_o,
  output logic                     busy_o
);
  localparam int OW = $clog2(WORDS);
  localparam int CW = OW + 1;
  localparam int BW = 16 - OW - 1;
  localparam bit CFG_OK = WORDS >= 2 && (WORDS & (WORDS - 1)) == 0 && MEM_LAT >= 1;
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [BW-1:0] base_q, base_d;
  logic mem_en_q, mem_en_d, busy_q, busy_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic grant, recv_v, last, unused_ok;
  assign grant = CFG_OK && state_q == ST_IDLE && (d_miss_i || i_miss_i);
  assign recv_v = state_q == ST_FILL && mem_data_valid_i;
  assign last = recv_v && recv_cnt == CW'(WORDS - 1);
  assign unused_ok = ^{i_miss_addr_i[OW:0], d_miss_addr_i[OW:0]};
  // issue_cnt holds the index of the word currently on mem_addr
  fill_word_counter #(.W(CW), .MAX(WORDS)) u_issue (
    .clk(clk), .rst_n(rst_n), .clr_i(grant), .en_i(mem_en_q), .cnt_o(issue_cnt)
  );
  fill_word_counter #(.W(CW), .MAX(WORDS)) u_recv (
    .clk(clk), .rst_n(rst_n), .clr_i(grant || last), .en_i(recv_v), .cnt_o(recv_cnt)
  );
  always_comb begin
    state_d = grant ? ST_FILL : last ? ST_DONE : state_q == ST_DONE ? ST_IDLE : state_q;
    owner_d = grant ? (d_miss_i ? OWN_D : OWN_I) : state_q == ST_DONE ? OWN_NONE : owner_q;
    base_d = !grant ? base_q : d_miss_i ? d_miss_addr_i[15:OW+1] : i_miss_addr_i[15:OW+1];
    mem_en_d = grant || (state_q == ST_FILL && mem_en_q && issue_cnt < CW'(WORDS - 1));
    mem_addr_d = !mem_en_d ? '0 :
      {base_d, grant ? {OW{1'b0}} : issue_cnt[OW-1:0] + 1'b1, 1'b0};
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      base_q <= '0;
      mem_en_q <= 1'b0;
      mem_addr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q <= base_d;
      mem_en_q <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q <= busy_d;
    end
  end
  assign mem_en_o = mem_en_q;
  assign mem_addr_o = mem_addr_q;
  assign busy_o = busy_q;
  assign fill_we_i_o = recv_v && owner_q == OWN_I;
  assign fill_we_d_o = recv_v && owner_q == OWN_D;
  assign tag_we_i_o = last && owner_q == OWN_I;
  assign tag_we_d_o = last && owner_q == OWN_D;
  assign fill_word_o = recv_cnt[OW-1:0];
  assign fill_data_o = mem_data_in_i;
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequences refills of the instruction and data caches from the single shared main-memory read port. On a cache miss it grants the memory port to one requester and issues one block's worth of word reads. It then steers the returning words into the owning cache's data array and writes the tag when the last word arrives. It sits between the IF/MEM-stage cache miss logic and the memory model; the pipeline stalls on the miss signals themselves.

## Interface
- `WORDS`, 8: 16-bit words per cache block. Must be a power of two, at least 2.
- `MEM_LAT`, 4: cycles from `mem_en` to the matching `mem_data_valid`. The memory is pipelined and returns data in issue order.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_miss` in 1: I-cache miss. A level signal, held until the cache reports a hit.
- `i_miss_addr` in 16: I-side miss byte address.
- `d_miss` in 1: D-cache miss. A level signal, held until the cache reports a hit.
- `d_miss_addr` in 16: D-side miss byte address.
- `mem_en` out 1: read request to memory, one word per cycle.
- `mem_addr` out 16: byte address of the requested word.
- `mem_data_valid` in 1: returned word is valid this cycle.
- `mem_data_in` in 16: returned word.
- `fill_we_i` out 1: write `fill_data` into the I-cache data array at `fill_word`.
- `fill_we_d` out 1: write `fill_data` into the D-cache data array at `fill_word`.
- `fill_word` out log2(WORDS): word offset within the block.
- `fill_data` out 16: equals `mem_data_in`.
- `tag_we_i` out 1: write the tag and set the valid bit for the I-side block. Asserted with the last word.
- `tag_we_d` out 1: write the tag and set the valid bit for the D-side block. Asserted with the last word.
- `busy` out 1: a fill is in progress, in FILL or DONE.

## Operation
States are IDLE, FILL and DONE. Owner is NONE, I or D.

**IDLE**
- Samples the miss inputs.
- If `d_miss` is high, owner becomes D. D has fixed priority because the MEM stage is older than IF.
- Otherwise, if `i_miss` is high, owner becomes I.
- On a grant: latch the block base as addr[15:log2(WORDS)+1], clear both counters, go to FILL.

**FILL**
- Issue counter runs 0..WORDS-1. While it is below WORDS:
  - `mem_en` = 1.
  - `mem_addr` = {base, issue_cnt, 1'b0}.
  - Increment the counter.
- Receive counter: on each `mem_data_valid`:
  - `fill_we_<owner>` = 1, `fill_word` = recv_cnt, `fill_data` = `mem_data_in`.
  - Increment the counter.
- When recv_cnt == WORDS-1 and `mem_data_valid` is high:
  - `tag_we_<owner>` = 1 in the same cycle.
  - Go to DONE.

**DONE**
- Lasts one cycle. It lets the cache re-probe and drop its miss.
- Then go to IDLE with owner NONE.
- The requester just served cannot be re-granted on the stale miss level, because the grant is only taken in IDLE.

**General rules**
- Miss inputs are ignored outside IDLE. A miss that arrives during a fill waits and is granted in the first IDLE cycle.
- A miss address that changes after the grant has no effect, since the base is latched.
- `mem_data_valid` in IDLE or DONE is ignored: no fill writes, counters unchanged.
- Combinational outputs (`fill_*`, `tag_*`) are gated by the owner. Only one of the I-side or D-side enables is ever high.

## Timing
- Every output is 0 in reset, state is IDLE, owner is NONE, both counters are 0.
- Reset asserted mid-fill aborts immediately:
  - no tag write;
  - the partially written block stays invalid;
  - data still in flight from memory after reset is ignored.
- Cycle numbering takes the grant cycle, when IDLE samples a miss, as cycle 0:
  - `mem_en` is high in cycles 1..WORDS;
  - data arrives in cycles 1+MEM_LAT..WORDS+MEM_LAT;
  - the tag write is in cycle WORDS+MEM_LAT (12 at defaults);
  - DONE is at 13 and IDLE at 14.
- Minimum spacing between two grants is WORDS+MEM_LAT+2 cycles (14 at defaults).
- `mem_en`, `mem_addr` and `busy` are registered.
- `fill_we_*`, `fill_word`, `fill_data` and `tag_we_*` are combinational from `mem_data_valid` and registered state.
- The receive counter wraps to 0 only on exit from FILL. It never counts past WORDS-1.

## Structure
- Shared package (`cache_pkg`) holds:
  - the state enum {IDLE, FILL, DONE};
  - the owner enum {NONE, I, D};
  - `WORDS` and the derived offset width;
  - the default `MEM_LAT`.
- One natural sub-module, `fill_word_counter`: a saturating log2(WORDS)+1-bit counter with clear and enable inputs. It is instantiated twice, once for the issue counter and once for the receive counter.

## Test plan
- **Single D miss.** `d_miss` = 1 with address 0x1236 in IDLE.
  - `mem_addr` 0x1230, 0x1232 … 0x123E in cycles 1-8.
  - `fill_we_d` in cycles 5-12 with `fill_word` 0-7.
  - `tag_we_d` in cycle 12; `busy` falls in cycle 14.
  - `fill_we_i` never asserted.
- **Simultaneous misses.** I at 0x0040 and D at 0x8000 in the same cycle.
  - D is served first (`mem_addr` 0x8000…).
  - The I grant occurs in the first IDLE after D's DONE; the I fill starts at 0x0040.
- **I miss arriving mid-fill.** `i_miss` rises in cycle 3 of a D fill: no I `mem_en` until D's DONE, then I is granted.
- **Reset mid-fill.** `rst_n` pulsed low in cycle 7.
  - All outputs are 0 immediately; no `tag_we_*` asserted.
  - Memory data returning in cycles 8-12 produces no `fill_we_*`.
- **Spurious valid.** `mem_data_valid` = 1 in IDLE with data 0xBEEF: no fill or tag write, counters remain 0.
- **Parameter sweep.** WORDS=4, MEM_LAT=1: tag write in cycle 5, four fill writes, `mem_addr` advances by 2.
